// File: rtl/textmode_pkg.sv
// Shared constants, command/state encodings and character sanitising for the
// text-mode console sequencer.
package textmode_pkg;

   localparam int COLS_DEF = 80;
   localparam int ROWS_DEF = 30;

   localparam logic [8:0] CHR_SPACE = 9'd32;
   localparam logic [8:0] CHR_SUBST = 9'd63;
   localparam logic [8:0] CHR_MIN   = 9'd32;
   localparam logic [8:0] CHR_MAX   = 9'd127;

   typedef enum logic [1:0] {
      OP_PUT     = 2'd0,
      OP_NEWLINE = 2'd1,
      OP_CLEAR   = 2'd2,
      OP_BKSP    = 2'd3
   } console_op_t;

   typedef enum logic [2:0] {
      ST_INIT_CLR  = 3'd0,
      ST_IDLE      = 3'd1,
      ST_PUT       = 3'd2,
      ST_BKSP      = 3'd3,
      ST_FILL_LINE = 3'd4,
      ST_FILL_ALL  = 3'd5
   } console_state_t;

   // Non-printable codes are shown as '?'.
   function automatic logic [8:0] chr_sanitize(input logic [8:0] c);
      logic [8:0] r;
      if ((c < CHR_MIN) || (c > CHR_MAX)) begin
         r = CHR_SUBST;
      end else begin
         r = c;
      end
      return r;
   endfunction

endpackage

// File: rtl/text_fill.sv
// Row/column sweep counter: issues one cell per cycle over a single row or the
// whole screen. The first cell is presented in the same cycle as i_start.
module text_fill
   import textmode_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic       i_all,
   input  logic [5:0] i_row,
   output logic [6:0] o_x,
   output logic [5:0] o_y,
   output logic       o_str,
   output logic       o_done
);

   localparam logic [6:0] X_LAST = 7'(COLS - 1);
   localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

   logic [6:0] r_x;
   logic [5:0] r_y;
   logic       r_all;
   logic       r_busy;
   logic       w_all;
   logic       w_last;

   // Current cell: a start overrides the counters so the sweep begins at once.
   always_comb begin
      o_str = 1'b0;
      o_x   = r_x;
      o_y   = r_y;
      w_all = r_all;
      if (i_start) begin
         o_str = 1'b1;
         o_x   = 7'd0;
         o_y   = i_all ? 6'd0 : i_row;
         w_all = i_all;
      end else if (r_busy) begin
         o_str = 1'b1;
      end else begin
         o_str = 1'b0;
      end
      w_last = (o_x == X_LAST) && (!w_all || (o_y == Y_LAST));
   end

   assign o_done = !r_busy;

   // Advance the sweep after each issued cell; the final cell stops it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= 7'd0;
         r_y    <= 6'd0;
         r_all  <= 1'b0;
         r_busy <= 1'b0;
      end else if (o_str) begin
         r_all <= w_all;
         if (w_last) begin
            r_busy <= 1'b0;
            r_x    <= o_x;
            r_y    <= o_y;
         end else if (o_x == X_LAST) begin
            r_busy <= 1'b1;
            r_x    <= 7'd0;
            r_y    <= o_y + 6'd1;
         end else begin
            r_busy <= 1'b1;
            r_x    <= o_x + 7'd1;
            r_y    <= o_y;
         end
      end
   end

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal-style command sequencer owning the text-mode write port: cursor
// tracking, command decode and registered write strobes.
module text_console_ctrl
   import textmode_pkg::*;
#(
   parameter int COLS           = COLS_DEF,
   parameter int ROWS           = ROWS_DEF,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic       clk_sys,
   input  logic       btn_rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [8:0] cmd_data,
   output logic [6:0] char_x,
   output logic [5:0] char_y,
   output logic [8:0] char_chr,
   output logic       char_str,
   output logic [6:0] cur_x,
   output logic [5:0] cur_y
);

   localparam logic [6:0] X_LAST = 7'(COLS - 1);
   localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

   console_state_t r_state;
   console_state_t w_nxt_state;
   logic           w_accept;
   logic [6:0]     w_nxt_x;
   logic [5:0]     w_nxt_y;
   logic [5:0]     w_next_row;
   logic           w_wr;
   logic [6:0]     w_wr_x;
   logic [8:0]     w_wr_chr;
   logic           w_fill_start;
   logic           w_fill_all;
   logic [5:0]     w_fill_row;
   logic [6:0]     w_fill_x;
   logic [5:0]     w_fill_y;
   logic           w_fill_str;
   logic           w_fill_done;

   assign w_accept   = cmd_valid && cmd_ready;
   assign w_next_row = (cur_y == Y_LAST) ? 6'd0 : cur_y + 6'd1;

   text_fill #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_fill (
      .clk     (clk_sys),
      .rst_n   (btn_rst_n),
      .i_start (w_fill_start),
      .i_all   (w_fill_all),
      .i_row   (w_fill_row),
      .o_x     (w_fill_x),
      .o_y     (w_fill_y),
      .o_str   (w_fill_str),
      .o_done  (w_fill_done)
   );

   // Command decode and next-state / next-cursor selection.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_x      = cur_x;
      w_nxt_y      = cur_y;
      w_wr         = 1'b0;
      w_wr_x       = cur_x;
      w_wr_chr     = CHR_SPACE;
      w_fill_start = 1'b0;
      w_fill_all   = 1'b0;
      w_fill_row   = cur_y;
      case (r_state)
         ST_INIT_CLR: begin
            w_fill_start = 1'b1;
            w_fill_all   = 1'b1;
            w_nxt_state  = ST_FILL_ALL;
         end
         ST_IDLE: begin
            if (w_accept) begin
               case (console_op_t'(cmd_op))
                  OP_PUT: begin
                     w_wr        = 1'b1;
                     w_wr_chr    = chr_sanitize(cmd_data);
                     w_nxt_state = ST_PUT;
                     if (cur_x == X_LAST) begin
                        w_nxt_x = 7'd0;
                        w_nxt_y = w_next_row;
                     end else begin
                        w_nxt_x = cur_x + 7'd1;
                     end
                  end
                  OP_NEWLINE: begin
                     w_nxt_x      = 7'd0;
                     w_nxt_y      = w_next_row;
                     w_fill_start = 1'b1;
                     w_fill_row   = w_next_row;
                     w_nxt_state  = ST_FILL_LINE;
                  end
                  OP_CLEAR: begin
                     w_fill_start = 1'b1;
                     w_fill_all   = 1'b1;
                     w_nxt_state  = ST_FILL_ALL;
                  end
                  OP_BKSP: begin
                     w_nxt_state = ST_BKSP;
                     if (cur_x != 7'd0) begin
                        w_nxt_x = cur_x - 7'd1;
                        w_wr_x  = cur_x - 7'd1;
                        w_wr    = 1'b1;
                     end else begin
                        w_wr = 1'b0;
                     end
                  end
                  default: w_nxt_state = ST_IDLE;
               endcase
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         // After a PUT the cursor sits at column 0 only if it wrapped.
         ST_PUT: begin
            if (cur_x == 7'd0) begin
               w_fill_start = 1'b1;
               w_nxt_state  = ST_FILL_LINE;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_BKSP: w_nxt_state = ST_IDLE;
         ST_FILL_LINE: begin
            if (w_fill_done) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_state = ST_FILL_LINE;
            end
         end
         ST_FILL_ALL: begin
            if (w_fill_done) begin
               w_nxt_state = ST_IDLE;
               w_nxt_x     = 7'd0;
               w_nxt_y     = 6'd0;
            end else begin
               w_nxt_state = ST_FILL_ALL;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   // State, cursor and registered write-port outputs.
   always_ff @(posedge clk_sys or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         r_state   <= CLEAR_ON_RESET ? ST_INIT_CLR : ST_IDLE;
         cmd_ready <= 1'b0;
         cur_x     <= 7'd0;
         cur_y     <= 6'd0;
         char_x    <= 7'd0;
         char_y    <= 6'd0;
         char_chr  <= 9'd0;
         char_str  <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         cmd_ready <= (w_nxt_state == ST_IDLE);
         cur_x     <= w_nxt_x;
         cur_y     <= w_nxt_y;
         char_str  <= w_wr | w_fill_str;
         if (w_fill_str) begin
            char_x   <= w_fill_x;
            char_y   <= w_fill_y;
            char_chr <= CHR_SPACE;
         end else if (w_wr) begin
            char_x   <= w_wr_x;
            char_y   <= cur_y;
            char_chr <= w_wr_chr;
         end
      end
   end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: expected cell writes are queued as
// commands are issued and matched against every observed strobe.
module tb_text_console_ctrl;

   localparam int COLS = 80;
   localparam int ROWS = 30;

   logic       clk_sys   = 1'b0;
   logic       btn_rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op    = 2'd0;
   logic [8:0] cmd_data  = 9'd0;
   logic       cmd_ready;
   logic [6:0] char_x;
   logic [5:0] char_y;
   logic [8:0] char_chr;
   logic       char_str;
   logic [6:0] cur_x;
   logic [5:0] cur_y;

   int n_cmp = 0;
   int n_err = 0;
   logic [21:0] exp_q[$];
   int mx = 0;
   int my = 0;

   always #5 clk_sys = ~clk_sys;

   text_console_ctrl #(
      .COLS           (COLS),
      .ROWS           (ROWS),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk_sys   (clk_sys),
      .btn_rst_n (btn_rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .char_x    (char_x),
      .char_y    (char_y),
      .char_chr  (char_chr),
      .char_str  (char_str),
      .cur_x     (cur_x),
      .cur_y     (cur_y)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] exp_chr(input logic [8:0] c);
      return ((c < 9'd32) || (c > 9'd127)) ? 9'd63 : c;
   endfunction

   task automatic push_row(input int y);
      for (int x = 0; x < COLS; x++) exp_q.push_back({7'(x), 6'(y), 9'd32});
   endtask

   task automatic push_all();
      for (int y = 0; y < ROWS; y++) push_row(y);
   endtask

   // Every strobe must match the oldest outstanding expected write.
   always @(negedge clk_sys) begin
      if (btn_rst_n && char_str) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_strobe", 32'({char_x, char_y, char_chr}), 32'hFFFF_FFFF);
         end else begin
            check_val("strobe", 32'({char_x, char_y, char_chr}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_outs"}, 32'({char_str, char_x, char_y, char_chr}), 32'd0);
      check_val({tag, "_ready"}, 32'(cmd_ready), 32'd0);
      check_val({tag, "_cursor"}, 32'({cur_x, cur_y}), 32'd0);
   endtask

   // Release reset (called at a negedge) and follow the automatic screen clear.
   task automatic run_init();
      int lat;
      exp_q.delete();
      push_all();
      mx = 0;
      my = 0;
      btn_rst_n = 1'b1;
      @(negedge clk_sys);
      check_val("init_first_str", 32'(char_str), 32'd1);
      lat = 1;
      while (!cmd_ready && lat < 3000) begin
         @(negedge clk_sys);
         lat++;
      end
      check_val("init_latency", 32'(lat), 32'd2401);
      check_val("init_q_empty", 32'(exp_q.size()), 32'd0);
      check_val("init_cursor", 32'({cur_x, cur_y}), 32'd0);
   endtask

   // Issue one command (from a negedge), update the model and check timing.
   task automatic do_cmd(input logic [1:0] op, input logic [8:0] d);
      int   lat;
      int   exp_lat;
      logic exp_first;
      for (int i = 0; i < 3000 && !cmd_ready; i++) @(negedge clk_sys);
      check_val("ready_before_cmd", 32'(cmd_ready), 32'd1);
      exp_first = 1'b1;
      exp_lat   = 2;
      case (op)
         2'd0: begin
            exp_q.push_back({7'(mx), 6'(my), exp_chr(d)});
            if (mx == COLS - 1) begin
               mx = 0;
               my = (my == ROWS - 1) ? 0 : my + 1;
               push_row(my);
               exp_lat = COLS + 2;
            end else begin
               mx++;
            end
         end
         2'd1: begin
            mx = 0;
            my = (my == ROWS - 1) ? 0 : my + 1;
            push_row(my);
            exp_lat = COLS + 1;
         end
         2'd2: begin
            push_all();
            mx = 0;
            my = 0;
            exp_lat = ROWS * COLS + 1;
         end
         default: begin
            if (mx > 0) begin
               mx--;
               exp_q.push_back({7'(mx), 6'(my), 9'd32});
            end else begin
               exp_first = 1'b0;
            end
         end
      endcase
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      @(posedge clk_sys);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = 9'h1AA;
      @(negedge clk_sys);
      check_val("str_at_n1", 32'(char_str), 32'(exp_first));
      lat = 1;
      while (!cmd_ready && lat < 3000) begin
         @(negedge clk_sys);
         lat++;
      end
      check_val("latency", 32'(lat), 32'(exp_lat));
      check_val("cursor", 32'({cur_x, cur_y}), 32'({7'(mx), 6'(my)}));
      check_val("q_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk_sys);
      check_reset_outputs("reset");
      run_init();

      do_cmd(2'd0, 9'd65);
      do_cmd(2'd1, 9'd0);
      do_cmd(2'd1, 9'd0);
      do_cmd(2'd0, 9'd200);
      do_cmd(2'd0, 9'd31);
      do_cmd(2'd0, 9'd127);
      do_cmd(2'd0, 9'd32);
      for (int i = 0; i < 4; i++) do_cmd(2'd3, 9'd0);
      do_cmd(2'd3, 9'd0);
      do_cmd(2'd3, 9'd0);
      for (int i = 0; i < 3; i++) do_cmd(2'd1, 9'd0);
      for (int i = 0; i < 10; i++) do_cmd(2'd0, 9'(97 + i));
      do_cmd(2'd1, 9'd0);
      for (int i = 0; i < 23; i++) do_cmd(2'd1, 9'd0);
      for (int i = 0; i < COLS - 1; i++) do_cmd(2'd0, 9'(33 + i));
      do_cmd(2'd0, 9'd66);
      do_cmd(2'd0, 9'd300);
      do_cmd(2'd2, 9'd0);

      // Reset in the middle of a screen clear.
      for (int i = 0; i < 3000 && !cmd_ready; i++) @(negedge clk_sys);
      push_all();
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      @(posedge clk_sys);
      #1;
      cmd_valid = 1'b0;
      repeat (1000) @(negedge clk_sys);
      btn_rst_n = 1'b0;
      #1;
      check_reset_outputs("midclr_reset");
      exp_q.delete();
      repeat (2) @(negedge clk_sys);
      check_reset_outputs("midclr_hold");
      run_init();
      do_cmd(2'd0, 9'd90);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
